// File: rtl/misp_recovery_ctrl_pkg.sv
// Shared definitions for the mispredict recovery controller:
// recovery FSM states, default restore width and counter limits.
`ifndef XLEN
`define XLEN 32
`endif

package misp_recovery_ctrl_pkg;

    // Default number of map entries copied per restore cycle
    localparam int RESTORE_PER_CYCLE_DEF = 4;

    // Width and ceiling of the saturating recovery counter
    localparam int          CNT_W   = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_RESTORE  = 2'd2,
        S_REDIRECT = 2'd3
    } rec_state_e;

endpackage

// File: rtl/misp_recovery_ctrl_if.sv
// Handshake bundle between the branch unit / fetch side (master)
// and the recovery controller (slave).
interface misp_recovery_ctrl_if
    import misp_recovery_ctrl_pkg::*;
#(
    parameter int XLEN_P        = `XLEN,
    parameter int NUM_ARCH_REGS = 32
);
    localparam int IDX_W = $clog2(NUM_ARCH_REGS);

    logic              mispredict;
    logic [XLEN_P-1:0] mispredict_target_pc;
    logic              redirect_ready;
    logic              flush;
    logic              stall_front;
    logic              restore_en;
    logic [IDX_W-1:0]  restore_idx;
    logic              redirect_valid;
    logic [XLEN_P-1:0] redirect_pc;
    logic              busy;
    logic [CNT_W-1:0]  recovery_cnt;

    modport master (
        output mispredict,
        output mispredict_target_pc,
        output redirect_ready,
        input  flush,
        input  stall_front,
        input  restore_en,
        input  restore_idx,
        input  redirect_valid,
        input  redirect_pc,
        input  busy,
        input  recovery_cnt
    );

    modport slave (
        input  mispredict,
        input  mispredict_target_pc,
        input  redirect_ready,
        output flush,
        output stall_front,
        output restore_en,
        output restore_idx,
        output redirect_valid,
        output redirect_pc,
        output busy,
        output recovery_cnt
    );

endinterface

// File: rtl/misp_recovery_ctrl.sv
// Retire-time mispredict recovery: flush, restore rename map
// from arch map in groups, then redirect fetch to the target PC.
module misp_recovery_ctrl
    import misp_recovery_ctrl_pkg::*;
#(
    parameter int XLEN_P            = `XLEN,
    parameter int NUM_ARCH_REGS     = 32,
    parameter int RESTORE_PER_CYCLE = RESTORE_PER_CYCLE_DEF
) (
    input logic              clock,
    input logic              reset,
    misp_recovery_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_ARCH_REGS);

    localparam logic [IDX_W-1:0] LAST_IDX =
        IDX_W'(NUM_ARCH_REGS - RESTORE_PER_CYCLE);
    localparam logic [IDX_W-1:0] STEP =
        IDX_W'(RESTORE_PER_CYCLE);

    rec_state_e        r_state;
    logic              r_flush;
    logic              r_restore_en;
    logic [IDX_W-1:0]  r_restore_idx;
    logic              r_redirect_valid;
    logic [XLEN_P-1:0] r_redirect_pc;
    logic              r_busy;
    logic [CNT_W-1:0]  r_recovery_cnt;

    // Recovery FSM; every output is a register updated with the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_flush          <= 1'b0;
            r_restore_en     <= 1'b0;
            r_restore_idx    <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_busy           <= 1'b0;
            r_recovery_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.mispredict) begin
                        r_state       <= S_FLUSH;
                        r_flush       <= 1'b1;
                        r_busy        <= 1'b1;
                        r_restore_idx <= '0;
                        r_redirect_pc <= bus.mispredict_target_pc;
                        if (r_recovery_cnt != CNT_MAX) begin
                            r_recovery_cnt <= r_recovery_cnt + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    r_state       <= S_RESTORE;
                    r_flush       <= 1'b0;
                    r_restore_en  <= 1'b1;
                    r_restore_idx <= '0;
                end
                S_RESTORE: begin
                    if (r_restore_idx == LAST_IDX) begin
                        r_state          <= S_REDIRECT;
                        r_restore_en     <= 1'b0;
                        r_redirect_valid <= 1'b1;
                    end else begin
                        r_restore_idx <= r_restore_idx + STEP;
                    end
                end
                S_REDIRECT: begin
                    if (bus.redirect_ready) begin
                        r_state          <= S_IDLE;
                        r_redirect_valid <= 1'b0;
                        r_busy           <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.flush          = r_flush;
    assign bus.stall_front    = r_busy;
    assign bus.restore_en     = r_restore_en;
    assign bus.restore_idx    = r_restore_idx;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.busy           = r_busy;
    assign bus.recovery_cnt   = r_recovery_cnt;

endmodule

// File: tb/tb_misp_recovery_ctrl.sv
// Directed bench for misp_recovery_ctrl: cycle-accurate checks plus
// a redirect PC scoreboard and an every-cycle exclusivity check.
module tb_misp_recovery_ctrl;

    logic clk;
    logic rst;

    int total;
    int bad;

    logic [31:0] exp_pc[$];
    logic [15:0] exp_cnt;

    misp_recovery_ctrl_if #(
        .XLEN_P(32),
        .NUM_ARCH_REGS(32)
    ) bus ();

    misp_recovery_ctrl #(
        .XLEN_P(32),
        .NUM_ARCH_REGS(32),
        .RESTORE_PER_CYCLE(4)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flush"}, 32'(bus.flush), 0);
        chk({tag, "_rst_en"}, 32'(bus.restore_en), 0);
        chk({tag, "_idx"}, 32'(bus.restore_idx), 0);
        chk({tag, "_rvalid"}, 32'(bus.redirect_valid), 0);
        chk({tag, "_rpc"}, bus.redirect_pc, 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_stall"}, 32'(bus.stall_front), 0);
        chk({tag, "_cnt"}, 32'(bus.recovery_cnt), 0);
    endtask

    task automatic accept(input logic [31:0] pc);
        bus.mispredict           = 1'b1;
        bus.mispredict_target_pc = pc;
        exp_pc.push_back(pc);
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    // Full recovery; ready stays low for 'hold' redirect cycles
    task automatic recover(input string tag,
                           input logic [31:0] pc,
                           input int hold);
        accept(pc);
        bus.redirect_ready = (hold == 0);
        step();
        bus.mispredict = 1'b0;
        chk({tag, "_flush"}, 32'(bus.flush), 1);
        chk({tag, "_busy"}, 32'(bus.busy), 1);
        chk({tag, "_stall"}, 32'(bus.stall_front), 1);
        chk({tag, "_cnt"}, 32'(bus.recovery_cnt), 32'(exp_cnt));
        for (int k = 0; k < 8; k++) begin
            step();
            chk({tag, "_ren"}, 32'(bus.restore_en), 1);
            chk({tag, "_idx"}, 32'(bus.restore_idx), 32'(4 * k));
        end
        for (int h = 0; h <= hold; h++) begin
            step();
            chk({tag, "_rvalid"}, 32'(bus.redirect_valid), 1);
            chk({tag, "_rpc"}, bus.redirect_pc, pc);
            if (h == hold) bus.redirect_ready = 1'b1;
        end
        step();
        chk({tag, "_idle"}, 32'(bus.busy), 0);
        chk({tag, "_rv_off"}, 32'(bus.redirect_valid), 0);
        chk({tag, "_cnt_end"}, 32'(bus.recovery_cnt), 32'(exp_cnt));
    endtask

    // Redirect handshakes are matched against the scoreboard
    always @(negedge clk) begin
        if (!rst && bus.redirect_valid && bus.redirect_ready) begin
            if (exp_pc.size() == 0) begin
                chk("sb_unexpected", 32'(bus.redirect_valid), 0);
            end else begin
                chk("sb_pc", bus.redirect_pc, exp_pc.pop_front());
            end
        end
    end

    // Control pulses never overlap
    always @(negedge clk) begin
        total++;
        assert ($onehot0({bus.flush, bus.restore_en,
                          bus.redirect_valid})) else begin
            bad++;
            $error("FAIL exclusive observed=%b expected=onehot0",
                   {bus.flush, bus.restore_en, bus.redirect_valid});
        end
    end

    initial begin
        logic seen;
        total                    = 0;
        bad                      = 0;
        exp_cnt                  = 16'd0;
        rst                      = 1'b1;
        bus.mispredict           = 1'b0;
        bus.mispredict_target_pc = '0;
        bus.redirect_ready       = 1'b0;
        #2;
        chk_zero("reset");
        step();
        step();
        rst = 1'b0;
        step();
        chk_zero("post_reset");

        // Basic recovery, fetch ready immediately
        recover("basic", 32'h0000_1040, 0);

        // Fetch back-pressure for five cycles
        recover("hold", 32'h0000_1040, 5);

        // Second mispredict during RESTORE is ignored
        bus.redirect_ready = 1'b1;
        accept(32'h0000_1040);
        step();
        bus.mispredict = 1'b0;
        step();
        step();
        step();
        bus.mispredict           = 1'b1;
        bus.mispredict_target_pc = 32'h0000_2000;
        step();
        bus.mispredict = 1'b0;
        chk("ign_cnt", 32'(bus.recovery_cnt), 32'(exp_cnt));
        for (int k = 0; k < 5; k++) step();
        chk("ign_rvalid", 32'(bus.redirect_valid), 1);
        chk("ign_rpc", bus.redirect_pc, 32'h0000_1040);
        step();
        chk("ign_idle", 32'(bus.busy), 0);
        chk("ign_cnt_end", 32'(bus.recovery_cnt), 32'(exp_cnt));

        // Reset in the middle of RESTORE abandons the recovery
        accept(32'h0000_1040);
        step();
        bus.mispredict = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("mid_ren", 32'(bus.restore_en), 1);
        rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        exp_pc.delete();
        exp_cnt = 16'd0;
        step();
        step();
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (bus.redirect_valid || bus.busy) seen = 1'b1;
        end
        chk("no_redir_after_rst", 32'(seen), 0);

        // Mispredict held across the handshake cycle
        bus.redirect_ready = 1'b1;
        accept(32'h0000_1040);
        step();
        bus.mispredict = 1'b0;
        for (int k = 0; k < 8; k++) step();
        step();
        chk("b2b_rvalid", 32'(bus.redirect_valid), 1);
        bus.mispredict           = 1'b1;
        bus.mispredict_target_pc = 32'h0000_3000;
        step();
        chk("b2b_idle", 32'(bus.busy), 0);
        chk("b2b_cnt1", 32'(bus.recovery_cnt), 1);
        accept(32'h0000_3000);
        step();
        bus.mispredict = 1'b0;
        chk("b2b_flush", 32'(bus.flush), 1);
        chk("b2b_cnt2", 32'(bus.recovery_cnt), 2);
        for (int k = 0; k < 8; k++) step();
        step();
        chk("b2b_rvalid2", 32'(bus.redirect_valid), 1);
        chk("b2b_rpc2", bus.redirect_pc, 32'h0000_3000);
        step();
        chk("b2b_idle2", 32'(bus.busy), 0);

        // Counter saturation
        force dut.r_recovery_cnt = 16'hFFFF;
        step();
        release dut.r_recovery_cnt;
        step();
        exp_cnt = 16'hFFFF;
        chk("sat_pre", 32'(bus.recovery_cnt), 32'h0000_FFFF);
        recover("sat", 32'h0000_4000, 0);
        chk("sat_post", 32'(bus.recovery_cnt), 32'h0000_FFFF);

        step();
        chk("sb_empty", 32'(exp_pc.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/misp_recovery_ctrl.md
MISP_RECOVERY_CTRL -- requirements
Module: misp_recovery_ctrl

Interface
REQ-001 SHALL have parameter XLEN_P, default `XLEN, PC width.
REQ-002 SHALL have parameter NUM_ARCH_REGS, default 32, number of architectural map entries to restore.
REQ-003 SHALL have parameter RESTORE_PER_CYCLE, default 4, map entries restored per cycle; must divide NUM_ARCH_REGS.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clock  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high.
REQ-007 mispredict  input  1  retire-time mispredict from the branch resolution unit.
REQ-008 mispredict_target_pc  input  XLEN_P  corrected fetch PC, valid with mispredict.
REQ-009 redirect_ready  input  1  fetch accepts redirect.
REQ-010 flush  output  1  one-cycle pulse clearing ROB, RS, LSQ and in-flight FUs.
REQ-011 stall_front  output  1  blocks fetch and dispatch.
REQ-012 restore_en  output  1  copy arch map to rename map this cycle.
REQ-013 restore_idx  output  $clog2(NUM_ARCH_REGS)  first entry of the current restore group.
REQ-014 redirect_valid  output  1  redirect request to fetch.
REQ-015 redirect_pc  output  XLEN_P  latched target PC.
REQ-016 busy  output  1  high in any non-IDLE state.
REQ-017 recovery_cnt  output  16  saturating count of accepted mispredicts.

Function
REQ-018 SHALL implement FSM states IDLE, FLUSH, RESTORE, REDIRECT.
REQ-019 IDLE with mispredict=1 SHALL latch mispredict_target_pc into redirect_pc, increment recovery_cnt (saturate at 16'hFFFF), and go to FLUSH.
REQ-020 FLUSH SHALL assert flush for exactly one cycle, clear restore_idx to 0, then go to RESTORE.
REQ-021 RESTORE SHALL assert restore_en every cycle and advance restore_idx by RESTORE_PER_CYCLE per cycle; on the cycle restore_idx = NUM_ARCH_REGS-RESTORE_PER_CYCLE, go to REDIRECT (NUM_ARCH_REGS/RESTORE_PER_CYCLE cycles total, no wrap).
REQ-022 REDIRECT SHALL hold redirect_valid=1 and redirect_pc stable until redirect_ready=1; on the handshake cycle go to IDLE.
REQ-023 stall_front SHALL equal busy, registered-state based, no combinational path from mispredict.
REQ-024 Latency with defaults: mispredict at cycle t -> flush at t+1, restore_en t+2..t+9, redirect_valid from t+10, IDLE at t+11 if redirect_ready=1.
REQ-025 mispredict while not IDLE SHALL be ignored: no redirect_pc change, no count change.
REQ-026 mispredict in the REDIRECT handshake cycle SHALL be ignored; next IDLE cycle samples normally.
REQ-027 restore_en, flush and redirect_valid SHALL be mutually exclusive.
REQ-028 All outputs SHALL be driven from registers or state decode only.

Reset
REQ-029 reset SHALL immediately force state=IDLE, flush=0, restore_en=0, restore_idx=0, redirect_valid=0, redirect_pc=0, busy=0, stall_front=0, recovery_cnt=0.
REQ-030 reset mid-recovery SHALL abandon the sequence; no redirect issued after reset release until a new mispredict.

Structure
REQ-031 State enum type and RESTORE_PER_CYCLE default SHALL live in the shared sys_defs package; XLEN from existing `XLEN.
REQ-032 SHALL be a single module; no sub-module needed.

Verification
REQ-033 Reset, then mispredict=1, pc=0x0000_1040, redirect_ready=1 -> flush at t+1, restore_idx 0,4,...,28 over t+2..t+9, redirect_valid with pc 0x1040 at t+10, busy low at t+11, recovery_cnt=1.
REQ-034 Same with redirect_ready=0 for 5 cycles after t+10 -> redirect_valid and pc 0x1040 held steady through t+15, IDLE at t+16 after ready rises at t+15.
REQ-035 Second mispredict pc=0x2000 at t+4 during RESTORE -> ignored; redirect_pc stays 0x1040, recovery_cnt=1.
REQ-036 Assert reset at t+5 (RESTORE) -> all outputs zero asynchronously; no redirect_valid after release.
REQ-037 Back-to-back: mispredict pc=0x3000 held high at handshake cycle and next cycle -> second recovery starts from following IDLE cycle, recovery_cnt=2.
REQ-038 Force recovery_cnt to 16'hFFFF then mispredict -> count stays 16'hFFFF; assertions check REQ-027 exclusivity every cycle.
